// File: rtl/tdm_demux_8_if.sv
// Bus bundle for the 8-channel TDM receiver: the slot stream in, and the
// reconstructed parallel channels plus frame status out.
interface tdm_demux_8_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sof;
    logic [WIDTH-1:0] y0;
    logic [WIDTH-1:0] y1;
    logic [WIDTH-1:0] y2;
    logic [WIDTH-1:0] y3;
    logic [WIDTH-1:0] y4;
    logic [WIDTH-1:0] y5;
    logic [WIDTH-1:0] y6;
    logic [WIDTH-1:0] y7;
    logic             frame_valid;
    logic             frame_err;
    logic [2:0]       slot;

    // Stream source / consumer of the parallel channels
    modport master (
        output din, din_valid, sof,
        input  y0, y1, y2, y3, y4, y5, y6, y7, frame_valid, frame_err, slot
    );

    // The demultiplexer itself
    modport slave (
        input  din, din_valid, sof,
        output y0, y1, y2, y3, y4, y5, y6, y7, frame_valid, frame_err, slot
    );
endinterface

// File: rtl/tdm_demux_8.sv
// 8-slot TDM receiver: collects one slot per valid beat into shadow
// registers and publishes the whole frame to y0..y7 at once, with a
// one-cycle frame_valid pulse. An sof arriving mid-frame aborts the
// partial frame (frame_err pulse) and restarts capture at slot 0.
module tdm_demux_8 #(
    parameter int WIDTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    tdm_demux_8_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       slot_q;
    logic [WIDTH-1:0] shadow [0:7];
    logic [WIDTH-1:0] y_q    [0:7];
    logic             frame_valid_q;
    logic             frame_err_q;

    // Frame capture FSM: shadow fill, atomic output update and status pulses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            slot_q        <= 3'd0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                y_q[i]    <= '0;
            end
        end else begin
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            if (bus.din_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.sof) begin
                            shadow[0] <= bus.din;
                            slot_q    <= 3'd1;
                            state     <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.sof) begin
                            // Early sof: drop the partial frame, this beat is slot 0
                            frame_err_q <= 1'b1;
                            shadow[0]   <= bus.din;
                            slot_q      <= 3'd1;
                        end else begin
                            shadow[slot_q] <= bus.din;
                            slot_q         <= slot_q + 3'd1;
                            if (slot_q == 3'd7) begin
                                // Last slot bypasses the shadow so the frame lands in one edge
                                for (int i = 0; i < 7; i++) begin
                                    y_q[i] <= shadow[i];
                                end
                                y_q[7]        <= bus.din;
                                frame_valid_q <= 1'b1;
                                state         <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.y0          = y_q[0];
    assign bus.y1          = y_q[1];
    assign bus.y2          = y_q[2];
    assign bus.y3          = y_q[3];
    assign bus.y4          = y_q[4];
    assign bus.y5          = y_q[5];
    assign bus.y6          = y_q[6];
    assign bus.y7          = y_q[7];
    assign bus.frame_valid = frame_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.slot        = slot_q;

endmodule

// File: tb/tb_tdm_demux_8.sv
// Bench for tdm_demux_8: directed frames from the test plan plus a long
// randomized stream, all checked every cycle against a frame-buffer model.
module tb_tdm_demux_8;

    localparam int WIDTH = 4;

    typedef int arr8_t [8];

    logic clk;
    logic rst_n;

    tdm_demux_8_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux_8 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a list of slots received so far in the current frame
    int    fbuf [8];
    int    fcnt = 0;
    arr8_t exp_y = '{0, 0, 0, 0, 0, 0, 0, 0};
    int    exp_fv = 0;
    int    exp_fe = 0;
    bit    chk_en = 1'b0;

    int cyc = 0;
    int fv_cnt = 0;
    int fe_cnt = 0;
    int fv_cyc_prev = -1;
    int fv_cyc_last = -1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int get_y(input int i);
        case (i)
            0: return int'(bus.y0);
            1: return int'(bus.y1);
            2: return int'(bus.y2);
            3: return int'(bus.y3);
            4: return int'(bus.y4);
            5: return int'(bus.y5);
            6: return int'(bus.y6);
            default: return int'(bus.y7);
        endcase
    endfunction

    // Model update on each active edge, from the frame rules
    always @(posedge clk) begin
        cyc++;
        exp_fv = 0;
        exp_fe = 0;
        if (!rst_n) begin
            fcnt  = 0;
            exp_y = '{0, 0, 0, 0, 0, 0, 0, 0};
        end else if (bus.din_valid) begin
            if (bus.sof) begin
                if (fcnt > 0) exp_fe = 1;
                fbuf[0] = int'(bus.din);
                fcnt    = 1;
            end else if (fcnt > 0) begin
                fbuf[fcnt] = int'(bus.din);
                fcnt++;
                if (fcnt == 8) begin
                    exp_y  = fbuf;
                    exp_fv = 1;
                    fcnt   = 0;
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("y%0d", i), get_y(i), exp_y[i]);
            end
            chk("frame_valid", int'(bus.frame_valid), exp_fv);
            chk("frame_err", int'(bus.frame_err), exp_fe);
            chk("slot", int'(bus.slot), fcnt % 8);
            if (bus.frame_valid) begin
                fv_cnt++;
                fv_cyc_prev = fv_cyc_last;
                fv_cyc_last = cyc;
            end
            if (bus.frame_err) fe_cnt++;
        end
    end

    task automatic drive(input bit v, input bit s, input int d);
        @(negedge clk);
        bus.din_valid = v;
        bus.sof       = s;
        bus.din       = WIDTH'(d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0);
    endtask

    task automatic send_frame(input arr8_t d, input int gapmax);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, d[i]);
            if (gapmax > 0 && i < 7) idle($urandom_range(gapmax, 1));
        end
    endtask

    task automatic chk_y(input string name, input arr8_t e);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_y%0d", name, i), get_y(i), e[i]);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        bus.din       = '0;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_slot", int'(bus.slot), 0);
        chk("reset_fv", int'(bus.frame_valid), 0);
        chk_y("reset", '{0, 0, 0, 0, 0, 0, 0, 0});
        rst_n = 1'b1;

        // Contiguous frame
        fv_cnt = 0;
        send_frame('{4, 8, 1, 15, 3, 7, 0, 14}, 0);
        idle(3);
        chk("t1_fv_count", fv_cnt, 1);
        chk_y("t1", '{4, 8, 1, 15, 3, 7, 0, 14});

        // Same frame with gaps
        fv_cnt = 0;
        send_frame('{4, 8, 1, 15, 3, 7, 0, 14}, 3);
        idle(3);
        chk("t2_fv_count", fv_cnt, 1);
        chk_y("t2", '{4, 8, 1, 15, 3, 7, 0, 14});

        // Early sof after three slots
        fv_cnt = 0;
        fe_cnt = 0;
        drive(1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 8);
        drive(1'b1, 1'b0, 1);
        send_frame('{9, 2, 2, 2, 2, 2, 2, 2}, 0);
        idle(3);
        chk("t3_fe_count", fe_cnt, 1);
        chk("t3_fv_count", fv_cnt, 1);
        chk_y("t3", '{9, 2, 2, 2, 2, 2, 2, 2});

        // Stray beats while idle
        fv_cnt = 0;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 5);
        send_frame('{1, 2, 3, 4, 5, 6, 7, 8}, 0);
        idle(3);
        chk("t4_fv_count", fv_cnt, 1);
        chk_y("t4", '{1, 2, 3, 4, 5, 6, 7, 8});

        // Back-to-back frames
        fv_cnt = 0;
        send_frame('{4, 8, 1, 15, 3, 7, 0, 14}, 0);
        send_frame('{14, 0, 7, 3, 15, 1, 8, 4}, 0);
        idle(3);
        chk("t5_fv_count", fv_cnt, 2);
        chk("t5_fv_spacing", fv_cyc_last - fv_cyc_prev, 8);
        chk_y("t5", '{14, 0, 7, 3, 15, 1, 8, 4});

        // Reset after slot 4
        fv_cnt = 0;
        fe_cnt = 0;
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 11 - i);
        @(negedge clk);
        bus.din_valid = 1'b0;
        bus.sof       = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t6_slot", int'(bus.slot), 0);
        chk_y("t6_rst", '{0, 0, 0, 0, 0, 0, 0, 0});
        send_frame('{3, 1, 4, 1, 5, 9, 2, 6}, 0);
        idle(3);
        chk("t6_fv_count", fv_cnt, 1);
        chk("t6_fe_count", fe_cnt, 0);
        chk_y("t6", '{3, 1, 4, 1, 5, 9, 2, 6});

        // Randomized stream with occasional early sof and resets
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            rst_n         = ($urandom_range(499, 0) != 0);
            bus.din_valid = ($urandom_range(9, 0) < 7);
            bus.sof       = ($urandom_range(9, 0) < 2);
            bus.din       = WIDTH'($urandom);
        end
        rst_n = 1'b1;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
